// File: rtl/sobel_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sobel_pkg
//  Description : Shared defaults, pixel type, tap index constants and FSM
//                state encoding for the Sobel 3x3 window generator.
//  Revision    : 1.0 - initial release
// ============================================================================
package sobel_pkg;

    localparam int DEF_IMG_W = 32;
    localparam int DEF_IMG_H = 32;
    localparam int DEF_PIX_W = 8;

    typedef logic [DEF_PIX_W-1:0] pix_t;

    // Tap (r,c) occupies slot 3*r+c of the packed window
    localparam int TAP_R0C0 = 0;
    localparam int TAP_R0C1 = 1;
    localparam int TAP_R0C2 = 2;
    localparam int TAP_R1C0 = 3;
    localparam int TAP_R1C1 = 4;
    localparam int TAP_R1C2 = 5;
    localparam int TAP_R2C0 = 6;
    localparam int TAP_R2C1 = 7;
    localparam int TAP_R2C2 = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic int tap_index(input int r, input int c);
        return 3 * r + c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sobel_line_delay.sv
`default_nettype none
// ============================================================================
//  Module      : sobel_line_delay
//  Description : Fixed-length pixel delay line, advanced only when en is high.
//                Together with the 3-tap row registers it spans one image row.
//  Revision    : 1.0 - initial release
// ============================================================================
module sobel_line_delay
    import sobel_pkg::*;
#(
    parameter int DEPTH = DEF_IMG_W - 3,
    parameter int PIX_W = DEF_PIX_W
) (
    input  logic             clk,
    input  logic             en,
    input  logic [PIX_W-1:0] din,
    output logic [PIX_W-1:0] dout
);

    // Contents are don't-care after reset, so the storage carries no reset
    logic [PIX_W-1:0] r_mem [DEPTH];

    // Shift the whole line by one pixel on each enabled cycle
    always_ff @(posedge clk) begin
        if (en) begin
            r_mem[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                r_mem[i] <= r_mem[i-1];
            end
        end
    end

    assign dout = r_mem[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/sobel_window_gen.sv
`default_nettype none
// ============================================================================
//  Module      : sobel_window_gen
//  Description : Builds a 3x3 neighbourhood per centre pixel from a raster
//                pixel stream and emits it with the centre x/y coordinates.
//                Define SOBEL_WIN_PAD_EN to emit every centre with zero padding
//                (adds a FLUSH phase); otherwise only interior centres emit.
//  Revision    : 1.0 - initial release
// ============================================================================
module sobel_window_gen
    import sobel_pkg::*;
#(
    parameter int IMG_W = DEF_IMG_W,
    parameter int IMG_H = DEF_IMG_H,
    parameter int PIX_W = DEF_PIX_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     sof,
    input  logic                     pix_valid,
    input  logic [PIX_W-1:0]         pix_in,
    output logic                     pix_ready,
    output logic                     win_valid,
    output logic [9*PIX_W-1:0]       win,
    output logic [$clog2(IMG_W)-1:0] win_x,
    output logic [$clog2(IMG_H)-1:0] win_y,
    output logic                     frame_done
);

    localparam int c_xw  = $clog2(IMG_W);
    localparam int c_yow = $clog2(IMG_H);
    // One extra row bit so the counter can walk through the flush triggers
    localparam int c_yw  = $clog2(IMG_H) + 1;

    localparam logic [c_xw-1:0] c_x_zero      = '0;
    localparam logic [c_xw-1:0] c_x_one       = c_xw'(1);
    localparam logic [c_xw-1:0] c_x_last      = c_xw'(IMG_W - 1);
    localparam logic [c_yw-1:0] c_y_zero      = '0;
    localparam logic [c_yw-1:0] c_y_one       = c_yw'(1);
    localparam logic [c_yw-1:0] c_y_two       = c_yw'(2);
    localparam logic [c_yw-1:0] c_y_last      = c_yw'(IMG_H - 1);
    localparam logic [c_yw-1:0] c_y_flush_end = c_yw'(IMG_H + 1);
`ifdef SOBEL_WIN_PAD_EN
    localparam state_t c_end_state = ST_FLUSH;
`else
    localparam state_t c_end_state = ST_DONE;
`endif

    state_t            r_state;
    state_t            w_next_state;
    logic [c_xw-1:0]   r_x;
    logic [c_yw-1:0]   r_y;
    logic              r_pix_ready;
    logic              r_win_valid;
    logic [9*PIX_W-1:0] r_win;
    logic [c_xw-1:0]   r_win_x;
    logic [c_yow-1:0]  r_win_y;
    logic              r_frame_done;

    logic              w_accept;
    logic              w_restart;
    logic              w_adv;
    logic [c_xw-1:0]   w_cur_x;
    logic [c_yw-1:0]   w_cur_y;
    logic              w_x_wrap;
    logic              w_last_pix;
    logic              w_flush_end;
    logic [c_xw-1:0]   w_cx;
    logic [c_yw-1:0]   w_cy;
    logic              w_cvalid;
    logic              w_emit;
    logic [2:0]        w_keep_row;
    logic [2:0]        w_keep_col;
    logic [PIX_W-1:0]  w_din;
    logic [PIX_W-1:0]  w_ld0_out;
    logic [PIX_W-1:0]  w_ld1_out;
    logic [PIX_W-1:0]  r_row  [3][3];
    logic [PIX_W-1:0]  w_rows [3][3];
    logic [9*PIX_W-1:0] w_win;

    assign w_accept    = pix_valid && r_pix_ready;
    assign w_restart   = w_accept && sof;
    // A sof pixel is always (0,0), whatever the counters held before
    assign w_cur_x     = w_restart ? c_x_zero : r_x;
    assign w_cur_y     = w_restart ? c_y_zero : r_y;
    assign w_x_wrap    = (w_cur_x == c_x_last);
    assign w_last_pix  = w_x_wrap && (w_cur_y == c_y_last);
    assign w_flush_end = (r_x == c_x_zero) && (r_y == c_y_flush_end);
    assign w_din       = (r_state == ST_FLUSH) ? '0 : pix_in;

    // Next-state and pipeline-advance decode
    always_comb begin
        w_next_state = r_state;
        w_adv        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_restart) begin
                    w_next_state = ST_RUN;
                    w_adv        = 1'b1;
                end
            end
            ST_RUN: begin
                if (w_accept) begin
                    w_adv = 1'b1;
                    if (w_last_pix) w_next_state = c_end_state;
                end
            end
            ST_FLUSH: begin
                w_adv = 1'b1;
                if (w_flush_end) w_next_state = ST_DONE;
            end
            ST_DONE: begin
                w_adv        = w_restart;
                w_next_state = w_restart ? ST_RUN : ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // State register, trigger-position counters and ready flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_x         <= '0;
            r_y         <= '0;
            r_pix_ready <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_pix_ready <= (w_next_state != ST_FLUSH);
            if (w_adv) begin
                r_x <= w_x_wrap ? c_x_zero : w_cur_x + c_x_one;
                r_y <= w_x_wrap ? w_cur_y + c_y_one : w_cur_y;
            end
        end
    end

    // The trigger sits IMG_W+1 elements after the centre; step back one
    // column and one row, borrowing a row when the trigger is in column 0
    always_comb begin
        if (w_cur_x == c_x_zero) begin
            w_cx     = c_x_last;
            w_cy     = w_cur_y - c_y_two;
            w_cvalid = (w_cur_y >= c_y_two);
        end else begin
            w_cx     = w_cur_x - c_x_one;
            w_cy     = w_cur_y - c_y_one;
            w_cvalid = (w_cur_y >= c_y_one);
        end
    end

`ifdef SOBEL_WIN_PAD_EN
    assign w_emit     = w_adv && w_cvalid;
    assign w_keep_row = {(w_cy != c_y_last), 1'b1, (w_cy != c_y_zero)};
    assign w_keep_col = {(w_cx != c_x_last), 1'b1, (w_cx != c_x_zero)};
`else
    // Interior only: edge centres would see wrapped or missing neighbours
    assign w_emit     = w_adv && w_cvalid &&
                        (w_cx != c_x_zero) && (w_cx != c_x_last) &&
                        (w_cy != c_y_zero) && (w_cy < c_y_last);
    assign w_keep_row = 3'b111;
    assign w_keep_col = 3'b111;
`endif

    sobel_line_delay #(.DEPTH(IMG_W - 3), .PIX_W(PIX_W)) u_line1 (
        .clk  (clk),
        .en   (w_adv),
        .din  (r_row[2][0]),
        .dout (w_ld1_out)
    );

    sobel_line_delay #(.DEPTH(IMG_W - 3), .PIX_W(PIX_W)) u_line0 (
        .clk  (clk),
        .en   (w_adv),
        .din  (r_row[1][0]),
        .dout (w_ld0_out)
    );

    // Row contents as they will be after this cycle's shift
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            w_rows[r][0] = r_row[r][1];
            w_rows[r][1] = r_row[r][2];
        end
        w_rows[0][2] = w_ld0_out;
        w_rows[1][2] = w_ld1_out;
        w_rows[2][2] = w_din;
    end

    // Three-tap row shift registers
    always_ff @(posedge clk) begin
        if (w_adv) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    r_row[r][c] <= w_rows[r][c];
                end
            end
        end
    end

    // Pack the taps, zeroing any row/column that falls outside the image
    always_comb begin
        w_win = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (w_keep_row[r] && w_keep_col[c]) begin
                    w_win[tap_index(r, c)*PIX_W +: PIX_W] = w_rows[r][c];
                end
            end
        end
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_win_valid  <= 1'b0;
            r_win        <= '0;
            r_win_x      <= '0;
            r_win_y      <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_win_valid  <= w_emit;
            r_frame_done <= (r_state == ST_DONE);
            if (w_emit) begin
                r_win   <= w_win;
                r_win_x <= w_cx;
                r_win_y <= w_cy[c_yow-1:0];
            end
        end
    end

    assign pix_ready  = r_pix_ready;
    assign win_valid  = r_win_valid;
    assign win        = r_win;
    assign win_x      = r_win_x;
    assign win_y      = r_win_y;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_sobel_window_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sobel_window_gen
//  Description : Self-checking bench for sobel_window_gen. Expected windows
//                are derived from an image array and pushed to a scoreboard
//                queue; a monitor pops and compares on every win_valid.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sobel_window_gen;
    import sobel_pkg::*;

    localparam int W  = DEF_IMG_W;
    localparam int H  = DEF_IMG_H;
    localparam int PW = DEF_PIX_W;
`ifdef SOBEL_WIN_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif
    localparam int EXP_LOW = PAD ? W + 1 : 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                     rst_n     = 1'b0;
    logic                     sof       = 1'b0;
    logic                     pix_valid = 1'b0;
    pix_t                     pix_in    = '0;
    logic                     pix_ready;
    logic                     win_valid;
    logic [9*PW-1:0]          win;
    logic [$clog2(W)-1:0]     win_x;
    logic [$clog2(H)-1:0]     win_y;
    logic                     frame_done;

    sobel_window_gen #(.IMG_W(W), .IMG_H(H), .PIX_W(PW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sof        (sof),
        .pix_valid  (pix_valid),
        .pix_in     (pix_in),
        .pix_ready  (pix_ready),
        .win_valid  (win_valid),
        .win        (win),
        .win_x      (win_x),
        .win_y      (win_y),
        .frame_done (frame_done)
    );

    typedef struct {
        int              x;
        int              y;
        logic [9*PW-1:0] w;
        int              cyc;
    } exp_t;

    exp_t exp_q [$];
    int   fd_q  [$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    pix_t img [H][W];

    always @(posedge clk) cyc <= cyc + 1;

    // Which centres the block emits in this build
    function automatic bit emitted(input int cx, input int cy);
        if (PAD) return (cx >= 0) && (cx < W) && (cy >= 0) && (cy < H);
        return (cx >= 1) && (cx <= W - 2) && (cy >= 1) && (cy <= H - 2);
    endfunction

    // Neighbourhood straight from the image, zero outside its bounds
    function automatic logic [9*PW-1:0] model_win(input int cx, input int cy);
        logic [9*PW-1:0] v;
        v = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                int yy;
                int xx;
                yy = cy + r - 1;
                xx = cx + c - 1;
                if (yy >= 0 && yy < H && xx >= 0 && xx < W)
                    v[(3*r+c)*PW +: PW] = img[yy][xx];
            end
        end
        return v;
    endfunction

    // Stream element m triggers the window centred on m-W-1
    task automatic push_trigger(input int m, input int seen);
        int   n;
        exp_t e;
        n = m - W - 1;
        if (n < 0) return;
        e.x = n % W;
        e.y = n / W;
        if (!emitted(e.x, e.y)) return;
        e.w   = model_win(e.x, e.y);
        e.cyc = seen;
        exp_q.push_back(e);
    endtask

    // Called at a negedge; returns at the negedge after the pixel is taken
    task automatic drive_px(input bit s, input pix_t v, input int m, output int acc);
        int waited;
        waited = 0;
        acc    = -1;
        sof       = s;
        pix_valid = 1'b1;
        pix_in    = v;
        while (!pix_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!pix_ready) begin
            checks++;
            errors++;
            $display("FAIL pix_ready_timeout: ready still %0b after %0d cycles, want 1", pix_ready, waited);
        end else begin
            acc = cyc + 1;
            push_trigger(m, acc);
        end
        @(negedge clk);
        sof       = 1'b0;
        pix_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        pix_valid = 1'b0;
        sof       = 1'($urandom);
        pix_in    = pix_t'($urandom);
        @(negedge clk);
        sof = 1'b0;
    endtask

    task automatic send_frame(input int npix, input bit ramp, input bit gaps);
        int acc;
        int last;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                img[y][x] = ramp ? pix_t'((x + 32 * y) & 255) : pix_t'($urandom);
        acc = 0;
        for (int m = 0; m < npix; m++) begin
            if (gaps && $urandom_range(1) == 0) idle_cycle();
            drive_px(m == 0, img[m / W][m % W], m, acc);
        end
        if (npix == W * H) begin
            last = acc;
            if (PAD) begin
                for (int j = 0; j <= W; j++) push_trigger(W * H + j, acc + 1 + j);
                last = acc + 1 + W;
            end
            fd_q.push_back(last + 1);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (win_valid !== 1'b0 || win !== '0 || win_x !== '0 || win_y !== '0 ||
            frame_done !== 1'b0 || pix_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_%s: got valid=%b win=%h x=%0d y=%0d done=%b ready=%b, want all zero",
                     tag, win_valid, win, win_x, win_y, frame_done, pix_ready);
        end
    endtask

    int low_run = 0;
    bit low_ign = 1'b1;

    // Scoreboard monitor: every output event must match the queue head
    always @(negedge clk) begin
        if (win_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL window_unexpected: got (%0d,%0d) win=%h at cycle %0d, want no window",
                         win_x, win_y, win, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (int'(win_x) != e.x || int'(win_y) != e.y || win !== e.w || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL window: got (%0d,%0d) win=%h cyc=%0d, want (%0d,%0d) win=%h cyc=%0d",
                             win_x, win_y, win, cyc, e.x, e.y, e.w, e.cyc);
                end
            end
        end
        if (frame_done === 1'b1) begin
            checks++;
            if (fd_q.size() == 0) begin
                errors++;
                $display("FAIL frame_done_unexpected: got pulse at cycle %0d, want none", cyc);
            end else begin
                int t;
                t = fd_q.pop_front();
                if (cyc != t) begin
                    errors++;
                    $display("FAIL frame_done_time: got cycle %0d, want cycle %0d", cyc, t);
                end
            end
        end
        if (rst_n !== 1'b1) begin
            low_ign = 1'b1;
            low_run = 0;
        end else if (pix_ready === 1'b0) begin
            low_run++;
        end else begin
            if (low_run > 0 && !low_ign) begin
                checks++;
                if (low_run != EXP_LOW) begin
                    errors++;
                    $display("FAIL ready_low_run: got %0d cycles low, want %0d", low_run, EXP_LOW);
                end
            end
            low_run = 0;
            low_ign = 1'b0;
        end
    end

    initial begin
        int acc;
        repeat (3) @(negedge clk);
        check_reset_outputs("power_on");
        rst_n = 1'b1;

        // Pixels without sof are dropped while idle
        for (int i = 0; i < 4; i++) drive_px(1'b0, pix_t'($urandom), -1, acc);

        send_frame(W * H, 1'b1, 1'b0);
        send_frame(W * H, 1'b1, 1'b1);

        // sof at linear pixel 500 aborts the first frame
        send_frame(500, 1'b0, 1'b0);
        send_frame(W * H, 1'b0, 1'b0);

        // Reset in the middle of a frame
        send_frame(300, 1'b0, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("mid_frame");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) drive_px(1'b0, pix_t'($urandom), -1, acc);
        send_frame(W * H, 1'b0, 1'b1);

        // Back-to-back frames
        send_frame(W * H, 1'b0, 1'b0);
        send_frame(W * H, 1'b1, 1'b0);

        repeat (W + 50) @(negedge clk);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL windows_missing: got %0d still pending, want 0", exp_q.size());
        end
        checks++;
        if (fd_q.size() != 0) begin
            errors++;
            $display("FAIL frame_done_missing: got %0d still pending, want 0", fd_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
